// File: rtl/ex_div.sv
// EX-stage M-extension divider (DIV/DIVU/REM/REMU), radix-2 restoring, one bit per cycle.
// Holds the pipeline through stallreq_o until a single-cycle ready_o pulse.
module ex_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [1:0]      op_q, op_d;

  logic            is_signed, a_neg, b_neg, ovf;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] q_fix, r_fix, res_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    op_d    = op_q;

    is_signed = ~op_i[0];
    a_neg     = is_signed & dividend_i[XLEN-1];
    b_neg     = is_signed & divisor_i[XLEN-1];
    a_abs     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_abs     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    ovf       = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);

    rem_sh = {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d  = op_i;
          cnt_d = '0;
          // Special cases bypass CALC with their final values and no sign fix.
          if (divisor_i == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dividend_i};
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = S_DONE;
          end else if (ovf) begin
            quo_d   = {1'b1, {(XLEN-1){1'b0}}};
            rem_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = S_DONE;
          end else begin
            dvd_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            quo_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        dvd_d = {dvd_q[XLEN-2:0], 1'b0};
        rem_d = diff[XLEN] ? rem_sh : diff;
        quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    // Result is formed from next-state values so it is registered on entry to DONE.
    q_fix = q_neg_d ? (~quo_d + 1'b1) : quo_d;
    r_fix = r_neg_d ? (~rem_d[XLEN-1:0] + 1'b1) : rem_d[XLEN-1:0];
    res_d = op_d[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      op_q     <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      op_q    <= op_d;
      ready_o <= (state_d == S_DONE);
      if (state_d == S_DONE) result_o <= res_d;
    end
  end

  assign stallreq_o = !flush_i && (((state_q == S_IDLE) && start_i) || (state_q == S_CALC));

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, hand-written corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  ex_div #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit ov;
    sa = a;
    sb = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   ref_div = (b == 0) ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   ref_div = (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb);
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Runs one op from IDLE; checks result, latency and total stall cycles.
  // With hold=1 start_i stays high after DONE and post-DONE checks are skipped.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input bit hold);
    int  n, st;
    bit  seen;
    logic [31:0] res;
    @(negedge clk);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
    n = 0; st = 0; seen = 0; res = '0;
    #1;
    if (stallreq_o) st++;
    while (!seen && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      dividend_i = $urandom;
      divisor_i  = $urandom;
      if (stallreq_o) st++;
      if (ready_o) begin
        seen = 1;
        res  = result_o;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: no ready_o after %0d cycles", name, n);
      start_i = 1'b0;
      return;
    end
    check({name, " result"}, res, exp);
    check({name, " latency"}, n, lat);
    check({name, " stall cycles"}, st, lat);
    if (!hold) begin
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({name, " post ready/stall"}, {30'd0, ready_o, stallreq_o}, 32'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] held, a, b;
    logic [1:0]  op;
    int          n;
    bit          seen;

    vecs = '{
      '{2'b01, 32'd100,        32'd7,        32'd14,         33},
      '{2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  33},
      '{2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  33},
      '{2'b00, 32'd5,          32'd0,        32'hFFFF_FFFF,  1},
      '{2'b11, 32'd5,          32'd0,        32'd5,          1},
      '{2'b10, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9,  1},
      '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1},
      '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33},
      '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33},
      '{2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
      '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,         33},
      '{2'b11, 32'hFFFF_FFFF,  32'd1,        32'd0,          33},
      '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         33}
    };

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {result_o[29:0], ready_o, stallreq_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       begin a = $urandom_range(0, 1000); b = $urandom; end
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b), ref_lat(op, a, b), 1'b0);
    end

    // Flush wins over start in IDLE.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5;
    #1;
    check("flush+start stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flush+start no accept", {30'd0, ready_o, stallreq_o}, 32'd0);

    // Flush in CALC cycle 10 of DIVU 1000/3.
    held = result_o;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    check("calc stall before flush", {31'd0, stallreq_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush stall low", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0; start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o || stallreq_o) seen = 1;
    end
    check("flush no ready", {31'd0, seen}, 32'd0);
    check("flush result held", result_o, held);
    run_op("after flush 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b0);

    // Back-to-back with start_i held through DONE.
    run_op("b2b 20/4", 2'b01, 32'd20, 32'd4, 32'd5, 33, 1'b1);
    op_i = 2'b11; dividend_i = 32'd20; divisor_i = 32'd6;
    @(posedge clk);
    #1;
    check("b2b idle gap", {30'd0, ready_o, stallreq_o}, 32'd1);
    n = 1; seen = 0;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_o) seen = 1;
    end
    check("b2b second latency", n, 32'd34);
    check("b2b 20%6", result_o, 32'd2);
    start_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset in CALC cycle 20.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0; start_i = 1'b0;
    #1;
    check("mid reset outputs", {30'd0, ready_o, stallreq_o}, 32'd0);
    check("mid reset result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o || stallreq_o) seen = 1;
    end
    check("post reset idle", {31'd0, seen}, 32'd0);
    run_op("post reset 1000/7", 2'b01, 32'd1000, 32'd7, 32'd142, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle integer divider in the EX stage of the Buceros RV32 pipeline. It executes the M-extension DIV/DIVU/REM/REMU operations with a 32-iteration radix-2 restoring algorithm. It raises `stallreq_o`, which drives the pipeline controller's `stallreq_ex_i`, so the controller freezes the pipeline while a division is in flight.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  EX holds a divide op; held high by the stalled EX stage until `ready_o`.
- `op_i`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i`  in  XLEN  rs1 value; sampled only on the accepting cycle.
- `divisor_i`  in  XLEN  rs2 value; sampled only on the accepting cycle.
- `flush_i`  in  1  abort any operation in progress (branch/exception flush).
- `result_o`  out  XLEN  quotient or remainder; valid while `ready_o`=1.
- `ready_o`  out  1  result valid; single-cycle pulse.
- `stallreq_o`  out  1  stall request to the controller (combinational).

## Operation
- States:
  - IDLE: no operation in progress.
  - CALC: iterating.
  - DONE: result presented.
- Accept: IDLE with `start_i`=1 and `flush_i`=0. Latch the operands and op; compute the absolute values for signed ops (DIV/REM); record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
- Special cases, decided at accept, go IDLE→DONE directly:
  - Divisor zero: quotient = 32'hFFFF_FFFF; remainder = dividend. Applies to all four ops.
  - Signed overflow (DIV/REM, dividend 32'h8000_0000, divisor 32'hFFFF_FFFF): quotient = 32'h8000_0000; remainder = 0.
- Normal case: IDLE→CALC, 6-bit iteration counter cleared to 0.
- CALC iteration, one per cycle, on a 33-bit partial remainder and a 32-bit quotient register:
  - Shift the next dividend MSB into the remainder.
  - Trial-subtract the divisor (33-bit subtract).
  - If the result is non-negative, keep it and shift a 1 into the quotient; otherwise shift a 0.
  - After iteration 31 (counter=31), go to DONE.
- DONE:
  - Apply sign fix: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (two's complement, 32-bit wrap).
  - Select the quotient for op 00/01 and the remainder for op 10/11 into the registered `result_o`.
  - Assert `ready_o`.
  - Next state is always IDLE.
- `stallreq_o` = (IDLE & `start_i` & !`flush_i`) | CALC. It is low in DONE, so the pipeline advances on the DONE cycle.
- `start_i` is ignored in CALC and DONE. It is honoured again only in IDLE, so a held-high `start_i` from the next instruction starts a new division one cycle after DONE.
- `flush_i`=1 in any state: next state IDLE, `ready_o` low next cycle, counter cleared. `stallreq_o` is forced low in the same cycle. `result_o` is not updated.
- `result_o` holds its last value outside DONE until the next completion.

## Timing
- Reset values: state IDLE, `result_o`=0, `ready_o`=0, counter=0, internal registers 0. `stallreq_o`=0 for as long as `start_i`=0.
- Reset asserted mid-operation: immediate return to IDLE with all of the above values; no result is produced.
- Latency for the normal path, with the accept edge counted as cycle 0:
  - Cycles 1..32: CALC.
  - Cycle 33: DONE (`ready_o`=1).
  - 34 cycles of `start_i` high in total.
- Special-case latency: accept at cycle 0, DONE at cycle 1 (`ready_o`=1); `stallreq_o` high for exactly one cycle.
- `stallreq_o` is high from the cycle `start_i` rises through the last CALC cycle, and falls in the DONE cycle.
- `ready_o` never stays high for two consecutive cycles.
- Simultaneous `flush_i` and `start_i` in IDLE: flush wins; no accept.
- Simultaneous `flush_i` and DONE: `ready_o` is still high that cycle (already registered); the controller discards it. Next state is IDLE.

## Test plan
- DIVU 100/7, `start_i` held: `stallreq_o`=1 for 33 cycles; `ready_o` on cycle 33 with `result_o`=14; next cycle IDLE and `stallreq_o`=0.
- REM −7 (32'hFFFF_FFF9) by 2 → `result_o`=32'hFFFF_FFFF (−1). DIV −7/2 → 32'hFFFF_FFFD (−3).
- DIV 5/0 → 32'hFFFF_FFFF at cycle 1. REMU 5/0 → 5. DIV 32'h8000_0000 / −1 → 32'h8000_0000 at cycle 1. REM of the same operands → 0.
- `flush_i` pulsed at CALC cycle 10 of DIVU 1000/3: `stallreq_o` low that cycle; no `ready_o`; `result_o` unchanged. A fresh DIVU 9/3 then yields 3 after 33 cycles.
- Back-to-back: DIVU 20/4 then REMU 20/6 with `start_i` held continuously: results 5 then 2; second accept one cycle after the first DONE.
- `rst_n` asserted at CALC cycle 20: all outputs zero immediately; after release with `start_i`=0, `stallreq_o`=0 and state IDLE.
